// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter family: FSM state encoding,
// default datapath parameters and the start-timeout counter width.
package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 8;
   localparam int DEFAULT_START_TIMEOUT = 15;
   localparam int TIMEOUT_CNT_WIDTH     = 8;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] idx
);

   // Rotate the request vector so that the requester at ptr sits at bit 0.
   logic [NUM_REQ-1:0] rot;
   int                 off;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot[gi] = req[IDX_WIDTH'((int'(ptr) + gi) % NUM_REQ)];
      end
   endgenerate

   always_comb begin
      found = 1'b0;
      off   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      idx = IDX_WIDTH'((int'(ptr) + off) % NUM_REQ);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit datapath between NUM_REQ byte requesters with
// per-byte round-robin, optional packet lock and a sticky start-timeout flag.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int IDX_WIDTH     = 2,
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_load,
   input  logic                          tx_busy,
   output logic [IDX_WIDTH-1:0]          grant_idx,
   output logic                          locked,
   output logic                          err_timeout
);

   arb_state_t                   state_reg, state_next;
   logic [IDX_WIDTH-1:0]         ptr_reg, ptr_next;
   logic [IDX_WIDTH-1:0]         grant_idx_reg, grant_idx_next;
   logic [DATA_WIDTH-1:0]        tx_data_reg, tx_data_next;
   logic                         last_reg, last_next;
   logic                         locked_reg, locked_next;
   logic                         err_timeout_reg, err_timeout_next;
   logic [TIMEOUT_CNT_WIDTH-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic [TIMEOUT_CNT_WIDTH-1:0] timeout_cnt_inc;

   logic [DATA_WIDTH-1:0]        req_bytes [NUM_REQ];
   logic                         pick_found;
   logic [IDX_WIDTH-1:0]         pick_idx;
   logic                         cand_found;
   logic [IDX_WIDTH-1:0]         cand_idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // A held lock narrows the choice to the lock owner, even if it has nothing to send.
   always_comb begin
      cand_found = pick_found;
      cand_idx   = pick_idx;
      if (locked_reg) begin
         cand_found = req_valid[grant_idx_reg];
         cand_idx   = grant_idx_reg;
      end
   end

   assign timeout_cnt_inc = timeout_cnt_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= '0;
         grant_idx_reg   <= '0;
         tx_data_reg     <= '0;
         last_reg        <= 1'b0;
         locked_reg      <= 1'b0;
         err_timeout_reg <= 1'b0;
         timeout_cnt_reg <= '0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         grant_idx_reg   <= grant_idx_next;
         tx_data_reg     <= tx_data_next;
         last_reg        <= last_next;
         locked_reg      <= locked_next;
         err_timeout_reg <= err_timeout_next;
         timeout_cnt_reg <= timeout_cnt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      grant_idx_next   = grant_idx_reg;
      tx_data_next     = tx_data_reg;
      last_next        = last_reg;
      locked_next      = locked_reg;
      err_timeout_next = err_timeout_reg;
      timeout_cnt_next = timeout_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (!tx_busy && cand_found) begin
               tx_data_next   = req_bytes[cand_idx];
               grant_idx_next = cand_idx;
               last_next      = req_last[cand_idx];
               state_next     = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            locked_next      = ~last_reg;
            // Only a completed packet advances the pointer, so locked bytes never rotate.
            if (last_reg) begin
               if (grant_idx_reg == IDX_WIDTH'(NUM_REQ - 1)) begin
                  ptr_next = '0;
               end else begin
                  ptr_next = grant_idx_reg + 1'b1;
               end
            end
            timeout_cnt_next = '0;
            state_next       = ST_WAIT_START;
         end

         ST_WAIT_START: begin
            if (tx_busy) begin
               state_next = ST_WAIT_DONE;
            end else begin
               timeout_cnt_next = timeout_cnt_inc;
               if (timeout_cnt_inc == TIMEOUT_CNT_WIDTH'(START_TIMEOUT)) begin
                  err_timeout_next = 1'b1;
                  locked_next      = 1'b0;
                  state_next       = ST_IDLE;
               end
            end
         end

         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = (state_reg == ST_ISSUE) && (grant_idx_reg == IDX_WIDTH'(gi));
      end
   endgenerate

   assign tx_load     = (state_reg == ST_ISSUE);
   assign tx_data     = tx_data_reg;
   assign grant_idx   = grant_idx_reg;
   assign locked      = locked_reg;
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and transmitter models drive
// the DUT, a monitor pops expected grants on every tx_load.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int IDX_WIDTH     = 2;
   localparam int DATA_WIDTH    = 8;
   localparam int START_TIMEOUT = 15;
   localparam int B2B_GAP       = 14;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic [NUM_REQ-1:0]            req_valid = '0;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
   logic [NUM_REQ-1:0]            req_last = '0;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_load;
   logic                          tx_busy = 1'b0;
   logic [IDX_WIDTH-1:0]          grant_idx;
   logic                          locked;
   logic                          err_timeout;

   typedef struct packed {
      logic [IDX_WIDTH-1:0]  idx;
      logic [DATA_WIDTH-1:0] data;
      logic                  lock_after;
      logic                  chk_gap;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] rq[NUM_REQ][$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         tx_phase = 0;
   logic       tx_en = 1'b1;
   logic       tx_kill = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .IDX_WIDTH     (IDX_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .tx_busy     (tx_busy),
      .grant_idx   (grant_idx),
      .locked      (locked),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input int r, input logic [7:0] d, input logic l);
      rq[r].push_back({l, d});
   endtask

   task automatic expect_grant(input int r, input logic [7:0] d, input logic lk, input logic gap);
      exp_t e;
      e.idx        = IDX_WIDTH'(r);
      e.data       = d;
      e.lock_after = lk;
      e.chk_gap    = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() > 0 || tx_phase > 0 || tx_busy || req_valid != '0) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) fail_bound(name);
      repeat (3) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_data"}, 32'(tx_data), 0);
      check({tag, "_tx_load"}, 32'(tx_load), 0);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_grant_idx"}, 32'(grant_idx), 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_err_timeout"}, 32'(err_timeout), 0);
   endtask

   // Requesters: present the head of each queue, pop it on req_ready.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (rq[i].size() > 0) begin
            req_valid[i]                         = 1'b1;
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = rq[i][0][7:0];
            req_last[i]                          = rq[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   end

   // Transmitter: busy for 10 cycles starting 2 cycles after each tx_load.
   initial forever begin
      @(negedge clk);
      if (tx_kill) begin
         tx_phase = 0;
         tx_busy  = 1'b0;
      end else if (tx_phase > 0) begin
         tx_phase--;
         tx_busy = (tx_phase > 0) && (tx_phase <= 10);
      end else if (tx_load && tx_en) begin
         tx_phase = 12;
      end
   end

   // Monitor: every tx_load consumes one scoreboard entry.
   initial begin
      exp_t e;
      int   last_load_cyc = 0;
      logic lock_pending = 1'b0;
      logic lock_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (lock_pending) begin
            check("mon_locked_after_issue", 32'(locked), 32'(lock_exp));
            lock_pending = 1'b0;
         end
         if (tx_load) begin
            if (exp_q.size() == 0) begin
               check("mon_unexpected_tx_load", 32'(tx_load), 0);
            end else begin
               e = exp_q.pop_front();
               check("mon_tx_data", 32'(tx_data), 32'(e.data));
               check("mon_grant_idx", 32'(grant_idx), 32'(e.idx));
               check("mon_req_ready", 32'(req_ready), 32'(1) << e.idx);
               if (e.chk_gap) check("mon_b2b_gap", 32'(cyc - last_load_cyc), B2B_GAP);
               lock_pending = 1'b1;
               lock_exp     = e.lock_after;
            end
            last_load_cyc = cyc;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Single byte from requester 0, one-cycle latency.
      push_req(0, 8'hA5, 1'b1);
      expect_grant(0, 8'hA5, 1'b0, 1'b0);
      tick();
      check("t1_latency_tx_load", 32'(tx_load), 1);
      check("t1_latency_req_ready", 32'(req_ready), 32'b0001);
      tick();
      check("t1_tx_load_pulse", 32'(tx_load), 0);
      check("t1_req_ready_pulse", 32'(req_ready), 0);
      check("t1_tx_data_hold", 32'(tx_data), 32'hA5);
      wait_drain("t1_drain");

      // All four requesters valid from ptr 0: order 0,1,2,3,0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push_req(0, 8'h10, 1'b1);
      push_req(1, 8'h11, 1'b1);
      push_req(2, 8'h12, 1'b1);
      push_req(3, 8'h13, 1'b1);
      push_req(0, 8'h14, 1'b1);
      expect_grant(0, 8'h10, 1'b0, 1'b0);
      expect_grant(1, 8'h11, 1'b0, 1'b1);
      expect_grant(2, 8'h12, 1'b0, 1'b1);
      expect_grant(3, 8'h13, 1'b0, 1'b1);
      expect_grant(0, 8'h14, 1'b0, 1'b1);
      wait_drain("t2_drain");

      // Locked 3-byte packet from requester 1 while 0 and 2 wait (ptr is 1).
      push_req(1, 8'h21, 1'b0);
      push_req(1, 8'h22, 1'b0);
      push_req(1, 8'h23, 1'b1);
      push_req(0, 8'h30, 1'b1);
      push_req(2, 8'h32, 1'b1);
      expect_grant(1, 8'h21, 1'b1, 1'b0);
      expect_grant(1, 8'h22, 1'b1, 1'b1);
      expect_grant(1, 8'h23, 1'b0, 1'b1);
      expect_grant(2, 8'h32, 1'b0, 1'b1);
      expect_grant(0, 8'h30, 1'b0, 1'b1);
      wait_drain("t3_drain");

      // Transmitter never starts: err_timeout after 15 WAIT_START cycles.
      tx_en = 1'b0;
      push_req(1, 8'h44, 1'b0);
      expect_grant(1, 8'h44, 1'b1, 1'b0);
      n = 0;
      while (!tx_load && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_bound("t4_wait_tx_load");
      repeat (START_TIMEOUT) tick();
      check("t4_err_before_timeout", 32'(err_timeout), 0);
      tick();
      check("t4_err_at_timeout", 32'(err_timeout), 1);
      check("t4_locked_cleared", 32'(locked), 0);
      repeat (20) tick();
      check("t4_err_sticky", 32'(err_timeout), 1);
      check("t4_idle_no_load", 32'(tx_load), 0);
      tx_en = 1'b1;

      // Reset during WAIT_DONE with the lock held; then grant restarts from index 0.
      push_req(3, 8'h51, 1'b0);
      push_req(3, 8'h52, 1'b1);
      expect_grant(3, 8'h51, 1'b1, 1'b0);
      n = 0;
      while (!tx_busy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail_bound("t5_wait_busy");
      tick();
      check("t5_locked_in_wait_done", 32'(locked), 1);
      rst     = 1'b1;
      tx_kill = 1'b1;
      tick();
      check_reset_outputs("t5_reset");
      push_req(2, 8'h62, 1'b1);
      expect_grant(2, 8'h62, 1'b0, 1'b0);
      expect_grant(3, 8'h52, 1'b0, 1'b1);
      rst     = 1'b0;
      tx_kill = 1'b0;
      wait_drain("t5_drain");
      check("end_scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
